wb_extend_arbiter: RTL and testbench

- Shares one 32-to-64-bit extend unit between NUM_REQ write-back sources of the eBPF core: ALU32 result, load unit and helper-call return.
- Each source offers a 32-bit beat with a size code and a sign flag.
- The block arbitrates round-robin, zero- or sign-extends the beat (or joins two beats for a 64-bit value), and presents one registered 64-bit register-file write with a valid/ready handshake.
- Sits between the execute/load stages and the register-file write port.

---
 rtl/hermes_cpu_pkg.sv | 24 ++
 rtl/wb_extend_arbiter_if.sv | 35 +++
 rtl/wb_extend_unit.sv | 22 ++
 rtl/wb_extend_arbiter.sv | 160 ++++++++++++++++
 tb/tb_wb_extend_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hermes_cpu_pkg.sv
// Shared eBPF core definitions: data widths, write-back size codes, extend FSM states
// and the common zero left-pad helper.
package hermes_cpu_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned HALF_XLEN = 32;

    // Write-back beat size codes
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    // Extend-arbiter FSM states
    typedef logic [0:0] wb_state_t;
    localparam wb_state_t IDLE    = 1'b0;
    localparam wb_state_t HI_WAIT = 1'b1;

    // Zero-extend a half-width value to full register width
    function automatic logic [XLEN-1:0] left_pad(input logic [HALF_XLEN-1:0] val);
        return {{(XLEN - HALF_XLEN){1'b0}}, val};
    endfunction

endpackage

// File: rtl/wb_extend_arbiter_if.sv
// Requester-side beats and register-file write port of the write-back extend arbiter.
interface wb_extend_arbiter_if
    import hermes_cpu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned RD_W    = 4,
    parameter int unsigned SRC_W   = $clog2(NUM_REQ)
);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ*HALF_XLEN-1:0] req_data;
    logic [NUM_REQ*2-1:0]         req_size;
    logic [NUM_REQ-1:0]           req_sext;
    logic [NUM_REQ*RD_W-1:0]      req_rd;

    logic                         wb_valid;
    logic                         wb_ready;
    logic [XLEN-1:0]              wb_data;
    logic [RD_W-1:0]              wb_rd;
    logic [SRC_W-1:0]             wb_src;

    // Sources and register file
    modport master (
        output req_valid, req_data, req_size, req_sext, req_rd, wb_ready,
        input  req_ready, wb_valid, wb_data, wb_rd, wb_src
    );

    // Arbiter
    modport slave (
        input  req_valid, req_data, req_size, req_sext, req_rd, wb_ready,
        output req_ready, wb_valid, wb_data, wb_rd, wb_src
    );

endinterface

// File: rtl/wb_extend_unit.sv
// Combinational 32-to-64-bit extender for byte, half and word write-back beats.
module wb_extend_unit
    import hermes_cpu_pkg::*;
(
    input  logic [HALF_XLEN-1:0] data,
    input  logic [1:0]           size,
    input  logic                 sext,
    output logic [XLEN-1:0]      ext
);

    // Fill the upper bits with the selected width's sign bit, or with zeros
    always_comb begin
        ext = left_pad(data);
        case (size)
            SZ_B:    ext = {{(XLEN - 8){sext & data[7]}}, data[7:0]};
            SZ_H:    ext = {{(XLEN - 16){sext & data[15]}}, data[15:0]};
            SZ_W:    ext = sext ? {{HALF_XLEN{data[HALF_XLEN-1]}}, data} : left_pad(data);
            default: ext = left_pad(data);  // dword low beat is joined, not extended
        endcase
    end

endmodule

// File: rtl/wb_extend_arbiter.sv
// Round-robin arbiter sharing one extend unit between write-back sources. Produces one
// registered 64-bit register-file write per accepted beat, or per joined dword pair.
module wb_extend_arbiter
    import hermes_cpu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned RD_W    = 4,
    parameter int unsigned SRC_W   = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    wb_extend_arbiter_if.slave bus,
    output logic               err_proto,
    output logic               busy
);

    wb_state_t              state_q, state_d;
    logic [SRC_W-1:0]       rr_last_q, rr_last_d;
    logic [SRC_W-1:0]       hold_src_q, hold_src_d;
    logic [HALF_XLEN-1:0]   hold_lo_q, hold_lo_d;
    logic [RD_W-1:0]        hold_rd_q, hold_rd_d;

    logic                   wb_valid_q, wb_valid_d;
    logic [XLEN-1:0]        wb_data_q, wb_data_d;
    logic [RD_W-1:0]        wb_rd_q, wb_rd_d;
    logic [SRC_W-1:0]       wb_src_q, wb_src_d;
    logic                   err_q, err_d;

    logic                   out_free;
    logic                   grant_found;
    logic [SRC_W-1:0]       grant_idx;
    logic [SRC_W-1:0]       cand;
    logic                   accept;

    logic [HALF_XLEN-1:0]   sel_data;
    logic [1:0]             sel_size;
    logic                   sel_sext;
    logic [RD_W-1:0]        sel_rd;
    logic [XLEN-1:0]        ext_data;

    assign out_free = ~wb_valid_q | bus.wb_ready;
    // Gated by rst_n so no beat is ever acknowledged while reset is held
    assign accept   = grant_found & out_free & rst_n;

    // Grant selection: locked to the held source mid-dword, else round-robin after rr_last
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        if (state_q == HI_WAIT) begin
            grant_found = bus.req_valid[hold_src_q];
            grant_idx   = hold_src_q;
        end else begin
            for (int unsigned k = 1; k <= NUM_REQ; k++) begin
                cand = SRC_W'((32'(rr_last_q) + k) % NUM_REQ);
                if (!grant_found && bus.req_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
    end

    // Granted beat fields
    always_comb begin
        sel_data = bus.req_data[32'(grant_idx) * HALF_XLEN +: HALF_XLEN];
        sel_size = bus.req_size[32'(grant_idx) * 2 +: 2];
        sel_sext = bus.req_sext[grant_idx];
        sel_rd   = bus.req_rd[32'(grant_idx) * RD_W +: RD_W];
    end

    // One-hot acknowledge of the accepted beat
    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    wb_extend_unit u_extend (
        .data (sel_data),
        .size (sel_size),
        .sext (sel_sext),
        .ext  (ext_data)
    );

    // Next state: drain, load single beats, hold a dword low half, join the high half
    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        hold_src_d = hold_src_q;
        hold_lo_d  = hold_lo_q;
        hold_rd_d  = hold_rd_q;
        wb_valid_d = wb_valid_q & ~bus.wb_ready;
        wb_data_d  = wb_data_q;
        wb_rd_d    = wb_rd_q;
        wb_src_d   = wb_src_q;
        err_d      = err_q;
        if (accept) begin
            if (state_q == HI_WAIT) begin
                wb_valid_d = 1'b1;
                wb_data_d  = {sel_data, hold_lo_q};
                wb_rd_d    = hold_rd_q;
                wb_src_d   = hold_src_q;
                rr_last_d  = hold_src_q;
                state_d    = IDLE;
                // A malformed second beat is still used as the high word
                if (sel_size != SZ_D) begin
                    err_d = 1'b1;
                end
            end else if (sel_size == SZ_D) begin
                hold_lo_d  = sel_data;
                hold_rd_d  = sel_rd;
                hold_src_d = grant_idx;
                state_d    = HI_WAIT;
            end else begin
                wb_valid_d = 1'b1;
                wb_data_d  = ext_data;
                wb_rd_d    = sel_rd;
                wb_src_d   = grant_idx;
                rr_last_d  = grant_idx;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rr_last_q  <= SRC_W'(NUM_REQ - 1);
            hold_src_q <= '0;
            hold_lo_q  <= '0;
            hold_rd_q  <= '0;
            wb_valid_q <= 1'b0;
            wb_data_q  <= '0;
            wb_rd_q    <= '0;
            wb_src_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            hold_src_q <= hold_src_d;
            hold_lo_q  <= hold_lo_d;
            hold_rd_q  <= hold_rd_d;
            wb_valid_q <= wb_valid_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_src_q   <= wb_src_d;
            err_q      <= err_d;
        end
    end

    assign bus.wb_valid = wb_valid_q;
    assign bus.wb_data  = wb_data_q;
    assign bus.wb_rd    = wb_rd_q;
    assign bus.wb_src   = wb_src_q;
    assign err_proto    = err_q;
    assign busy         = (state_q != IDLE) | wb_valid_q;

endmodule

// File: tb/tb_wb_extend_arbiter.sv
// Scoreboard bench for wb_extend_arbiter: directed scenarios followed by random traffic.
module tb_wb_extend_arbiter;

    localparam int N     = 3;
    localparam int RD_W  = 4;
    localparam int SRC_W = 2;

    typedef struct {
        logic [63:0] data;
        logic [3:0]  rd;
        logic [1:0]  src;
    } exp_t;

    logic clk;
    logic rst_n;
    logic err_proto;
    logic busy;

    wb_extend_arbiter_if #(.NUM_REQ(N), .RD_W(RD_W), .SRC_W(SRC_W)) bus ();

    wb_extend_arbiter #(.NUM_REQ(N), .RD_W(RD_W), .SRC_W(SRC_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .err_proto (err_proto),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stimulus held by each source until accepted
    logic [N-1:0] r_valid;
    logic [31:0]  r_data [N];
    logic [1:0]   r_size [N];
    logic         r_sext [N];
    logic [3:0]   r_rd   [N];
    bit           phase  [N];
    logic         r_wb_ready;

    // Reference model state
    int          m_rr;
    bit          m_hi;
    int          m_held;
    logic [31:0] m_lo;
    logic [3:0]  m_hrd;
    bit          m_pending;
    bit          m_err;
    exp_t        sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model_ext(input logic [31:0] d, input logic [1:0] sz,
                                              input logic sx);
        longint v;
        case (sz)
            2'd0:    v = sx ? longint'($signed(d[7:0]))  : longint'(d[7:0]);
            2'd1:    v = sx ? longint'($signed(d[15:0])) : longint'(d[15:0]);
            default: v = sx ? longint'($signed(d))       : longint'(d);
        endcase
        return v;
    endfunction

    task automatic set_req(input int i, input logic [31:0] d, input logic [1:0] sz,
                           input logic sx, input logic [3:0] rd);
        r_valid[i] = 1'b1;
        r_data[i]  = d;
        r_size[i]  = sz;
        r_sext[i]  = sx;
        r_rd[i]    = rd;
    endtask

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.req_data[i*32 +: 32] = r_data[i];
            bus.req_size[i*2 +: 2]   = r_size[i];
            bus.req_sext[i]          = r_sext[i];
            bus.req_rd[i*4 +: 4]     = r_rd[i];
        end
        bus.req_valid = r_valid;
        bus.wb_ready  = r_wb_ready;
    endtask

    // One cycle: drive, compare handshake against the model, advance the model
    task automatic step();
        int           g;
        bit           acc;
        bit           free;
        bit           nxt_pending;
        logic [N-1:0] exp_ready;
        exp_t         e;
        @(negedge clk);
        apply();
        #1;
        free = !m_pending || r_wb_ready;
        g = -1;
        if (m_hi) begin
            if (r_valid[m_held]) g = m_held;
        end else begin
            for (int k = 1; k <= N; k++) begin
                int idx = (m_rr + k) % N;
                if (g < 0 && r_valid[idx]) g = idx;
            end
        end
        acc = (g >= 0) && free;
        exp_ready = '0;
        if (acc) exp_ready[g] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        chk("wb_valid", 64'(bus.wb_valid), 64'(m_pending));
        chk("err_proto", 64'(err_proto), 64'(m_err));
        chk("busy", 64'(busy), 64'(m_hi || m_pending));
        nxt_pending = m_pending && !r_wb_ready;
        if (acc) begin
            if (m_hi) begin
                if (r_size[g] != 2'd3) m_err = 1'b1;
                e.data = {r_data[g], m_lo};
                e.rd   = m_hrd;
                e.src  = 2'(g);
                sb.push_back(e);
                nxt_pending = 1'b1;
                m_rr = g;
                m_hi = 1'b0;
                phase[g] = 1'b0;
            end else if (r_size[g] == 2'd3) begin
                m_hi = 1'b1;
                m_held = g;
                m_lo = r_data[g];
                m_hrd = r_rd[g];
                phase[g] = 1'b1;
            end else begin
                e.data = model_ext(r_data[g], r_size[g], r_sext[g]);
                e.rd   = r_rd[g];
                e.src  = 2'(g);
                sb.push_back(e);
                nxt_pending = 1'b1;
                m_rr = g;
            end
            r_valid[g] = 1'b0;
        end
        m_pending = nxt_pending;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, 32'h0, 2'd2, 1'b0, 4'd0);
        apply();
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
        chk("rst_wb_data", bus.wb_data, 64'd0);
        chk("rst_wb_rd", 64'(bus.wb_rd), 64'd0);
        chk("rst_wb_src", 64'(bus.wb_src), 64'd0);
        chk("rst_err_proto", 64'(err_proto), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        r_valid = '0;
        apply();
        m_rr = N - 1;
        m_hi = 1'b0;
        m_held = 0;
        m_pending = 1'b0;
        m_err = 1'b0;
        sb.delete();
        for (int i = 0; i < N; i++) phase[i] = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    // Monitor: every presented write must match the oldest expected entry
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && bus.wb_valid) begin
                if (sb.size() == 0) begin
                    chk("wb_unexpected", 64'(bus.wb_valid), 64'd0);
                end else begin
                    chk("wb_data", bus.wb_data, sb[0].data);
                    chk("wb_rd", 64'(bus.wb_rd), 64'(sb[0].rd));
                    chk("wb_src", 64'(bus.wb_src), 64'(sb[0].src));
                    if (bus.wb_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        r_valid = '0;
        r_wb_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            set_req(i, 32'h0, 2'd0, 1'b0, 4'd0);
            phase[i] = 1'b0;
        end
        r_valid = '0;
        apply();
        do_reset();

        // Word, zero-extended
        set_req(0, 32'hFF0000FF, 2'd2, 1'b0, 4'd3);
        step();
        step();
        chk("t1_data", bus.wb_data, 64'h00000000_FF0000FF);
        chk("t1_rd", 64'(bus.wb_rd), 64'd3);
        chk("t1_src", 64'(bus.wb_src), 64'd0);

        // Sign-extended byte then half on consecutive cycles
        set_req(1, 32'h00000080, 2'd0, 1'b1, 4'd5);
        step();
        set_req(1, 32'h00007FFF, 2'd1, 1'b1, 4'd5);
        step();
        chk("t2_byte", bus.wb_data, 64'hFFFFFFFF_FFFFFF80);
        step();
        chk("t2_half", bus.wb_data, 64'h00000000_00007FFF);

        // Round-robin order with all sources busy
        do_reset();
        for (int c = 0; c < 6; c++) begin
            for (int i = 0; i < N; i++) set_req(i, $urandom, 2'd2, 1'b0, 4'(i));
            step();
            chk("t3_grant", 64'(bus.req_ready), 64'(1 << (c % 3)));
        end
        r_valid = '0;
        step();

        // Dword join locks out other sources
        do_reset();
        set_req(2, 32'h89ABCDEF, 2'd3, 1'b0, 4'd7);
        step();
        set_req(0, 32'h00000011, 2'd2, 1'b0, 4'd1);
        step();
        chk("t4_blocked", 64'(bus.req_ready), 64'd0);
        set_req(2, 32'h01234567, 2'd3, 1'b0, 4'd7);
        step();
        chk("t4_hi_accept", 64'(bus.req_ready), 64'b100);
        step();
        chk("t4_req0_next", 64'(bus.req_ready), 64'b001);
        chk("t4_join", bus.wb_data, 64'h01234567_89ABCDEF);
        chk("t4_src", 64'(bus.wb_src), 64'd2);
        step();

        // Backpressure holds output and blocks accepts
        set_req(0, 32'hDEADBEEF, 2'd2, 1'b1, 4'd2);
        step();
        r_wb_ready = 1'b0;
        set_req(1, 32'h00000042, 2'd0, 1'b0, 4'd6);
        for (int c = 0; c < 4; c++) begin
            step();
            chk("t5_stall", 64'(bus.req_ready), 64'd0);
            chk("t5_hold", bus.wb_data, 64'hFFFFFFFF_DEADBEEF);
        end
        r_wb_ready = 1'b1;
        step();
        chk("t5_replace", 64'(bus.req_ready), 64'b010);
        step();

        // Malformed second beat, then reset while a low half is held
        set_req(1, 32'hCAFEF00D, 2'd3, 1'b0, 4'd9);
        step();
        set_req(1, 32'h00000055, 2'd2, 1'b0, 4'd9);
        step();
        step();
        chk("t6_err", 64'(err_proto), 64'd1);
        chk("t6_join", bus.wb_data, 64'h00000055_CAFEF00D);
        set_req(0, 32'h00000001, 2'd3, 1'b0, 4'd4);
        step();
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 32'h10 + 32'(i), 2'd2, 1'b0, 4'(i));
        step();
        chk("t6_after_rst", 64'(bus.req_ready), 64'b001);

        // Random traffic
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!r_valid[i] && $urandom_range(0, 3) != 0) begin
                    r_data[i] = $urandom;
                    r_rd[i]   = 4'($urandom_range(0, 10));
                    r_sext[i] = 1'($urandom_range(0, 1));
                    if (phase[i]) r_size[i] = ($urandom_range(0, 15) == 0) ? 2'd2 : 2'd3;
                    else r_size[i] = 2'($urandom_range(0, 3));
                    r_valid[i] = 1'b1;
                end
            end
            r_wb_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        r_valid = '0;
        r_wb_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        #5;
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
